// File: rtl/mod_inv64_module.sv
// Modular inverse P = A^-1 mod N by the binary extended Euclidean algorithm,
// one iteration per clock, with a start/done level handshake.
module mod_inv64_module #(
   parameter int unsigned N_WIDTH = 64
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [N_WIDTH-1:0] i_a,
   input  logic [N_WIDTH-1:0] i_n,
   output logic [N_WIDTH-1:0] o_p,
   output logic               o_done,
   output logic               o_err
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e             r_state;
   logic [N_WIDTH-1:0] r_u;
   logic [N_WIDTH-1:0] r_v;
   logic [N_WIDTH-1:0] r_x1;
   logic [N_WIDTH-1:0] r_x2;
   logic [N_WIDTH-1:0] r_nr;
   logic [N_WIDTH-1:0] r_p;
   logic               r_done;
   logic               r_err;

   logic [N_WIDTH:0]   w_x1_sum;
   logic [N_WIDTH:0]   w_x2_sum;
   logic [N_WIDTH:0]   w_x1_diff;
   logic [N_WIDTH:0]   w_x2_diff;
   logic [N_WIDTH-1:0] w_x1_half;
   logic [N_WIDTH-1:0] w_x2_half;
   logic [N_WIDTH-1:0] w_x1_sub;
   logic [N_WIDTH-1:0] w_x2_sub;
   logic               w_bad_ops;

   // Halving mod Nr: an odd x gets Nr added first (Nr is odd) so the sum is even.
   always_comb begin
      w_x1_sum  = {1'b0, r_x1} + {1'b0, r_nr};
      w_x2_sum  = {1'b0, r_x2} + {1'b0, r_nr};
      w_x1_half = r_x1[0] ? w_x1_sum[N_WIDTH:1] : (r_x1 >> 1);
      w_x2_half = r_x2[0] ? w_x2_sum[N_WIDTH:1] : (r_x2 >> 1);
      w_x1_diff = {1'b0, r_x1} - {1'b0, r_x2};
      w_x2_diff = {1'b0, r_x2} - {1'b0, r_x1};
      w_x1_sub  = w_x1_diff[N_WIDTH] ? (w_x1_diff[N_WIDTH-1:0] + r_nr)
                                     : w_x1_diff[N_WIDTH-1:0];
      w_x2_sub  = w_x2_diff[N_WIDTH] ? (w_x2_diff[N_WIDTH-1:0] + r_nr)
                                     : w_x2_diff[N_WIDTH-1:0];
      w_bad_ops = ~i_n[0] | (i_n < N_WIDTH'(3)) | (i_a >= i_n);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_u     <= '0;
         r_v     <= '0;
         r_x1    <= '0;
         r_x2    <= '0;
         r_nr    <= '0;
         r_p     <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_u    <= i_a;
                  r_v    <= i_n;
                  r_x1   <= N_WIDTH'(1);
                  r_x2   <= '0;
                  r_nr   <= i_n;
                  r_p    <= '0;
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  if (w_bad_ops) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= StRun;
                  end
               end
            end
            StRun: begin
               if (r_u == N_WIDTH'(1)) begin
                  r_p     <= r_x1;
                  r_err   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end else if (r_v == N_WIDTH'(1)) begin
                  r_p     <= r_x2;
                  r_err   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end else if (r_u == '0) begin
                  // gcd(A,N) > 1 (or A == 0): no inverse exists
                  r_p     <= '0;
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end else if (!r_u[0]) begin
                  r_u  <= r_u >> 1;
                  r_x1 <= w_x1_half;
               end else if (!r_v[0]) begin
                  r_v  <= r_v >> 1;
                  r_x2 <= w_x2_half;
               end else if (r_u >= r_v) begin
                  r_u  <= r_u - r_v;
                  r_x1 <= w_x1_sub;
               end else begin
                  r_v  <= r_v - r_u;
                  r_x2 <= w_x2_sub;
               end
            end
            StDone: begin
               // Level handshake: only a dropped start re-arms the block
               if (!i_start) begin
                  r_done  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_p    = r_p;
   assign o_done = r_done;
   assign o_err  = r_err;

endmodule
